// File: rtl/div8_seq_pkg.sv
// Shared widths, state encodings and constants for the sequential 8-bit divider.
package div8_seq_pkg;

  localparam int unsigned DIV_W = 8;
  localparam logic [2:0] ITER_LAST = 3'd7;
  localparam logic [DIV_W-1:0] DZ_QUOT = 8'hFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/div8_seq_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface div8_seq_if;
  import div8_seq_pkg::*;

  logic             start;
  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [DIV_W-1:0] quotient;
  logic [DIV_W-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/sub8_unit.sv
// 8-bit ripple subtractor a + ~b + 1 built from full adders; cout=1 means no borrow.
module sub8_unit
  import div8_seq_pkg::*;
(
  input  logic [DIV_W-1:0] a,
  input  logic [DIV_W-1:0] b,
  output logic [DIV_W-1:0] diff,
  output logic             cout
);

  logic [DIV_W:0]   carry;
  logic [DIV_W-1:0] b_inv;

  assign carry[0] = 1'b1;
  assign b_inv    = ~b;

  for (genvar i = 0; i < DIV_W; i++) begin : g_fa
    assign diff[i]      = a[i] ^ b_inv[i] ^ carry[i];
    assign carry[i+1]   = (a[i] & b_inv[i]) | (carry[i] & (a[i] ^ b_inv[i]));
  end

  assign cout = carry[DIV_W];

endmodule

// File: rtl/div8_seq.sv
// Sequential restoring divider: one quotient bit per cycle through sub8_unit,
// results held in output registers until the next operation completes.
module div8_seq
  import div8_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  div8_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] q_q, q_d, r_q, r_d, d_q, d_d;
  logic [DIV_W-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [DIV_W:0]   trial;
  logic [DIV_W-1:0] diff, r_step, q_step;
  logic             cout, ge;

  assign trial = {r_q, q_q[DIV_W-1]};

  sub8_unit u_sub (
    .a    (trial[DIV_W-1:0]),
    .b    (d_q),
    .diff (diff),
    .cout (cout)
  );

  // trial[8] set means the trial value is >= 256 > divisor, so subtraction always succeeds.
  assign ge     = trial[DIV_W] | cout;
  assign r_step = ge ? diff : trial[DIV_W-1:0];
  assign q_step = {q_q[DIV_W-2:0], ge};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          q_d   = bus.dividend;
          d_d   = bus.divisor;
          r_d   = '0;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            state_d = StDone;
            quot_d  = DZ_QUOT;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == ITER_LAST) begin
          state_d = StDone;
          quot_d  = q_step;
          rem_d   = r_step;
          dbz_d   = 1'b0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == StCalc);
  assign bus.done        = (state_q == StDone);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8_seq.sv
// Randomized and directed bench for div8_seq against an arithmetic (/ and %) model.
module tb_div8_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  div8_seq_if bus ();

  div8_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues start there and returns at the negedge after the done cycle.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input bit poke);
    logic [7:0] exp_q, exp_r;
    bit         exp_dz;
    int         nbusy, ndone;
    if (b == 8'd0) begin
      exp_q  = 8'hFF;
      exp_r  = a;
      exp_dz = 1'b1;
    end else begin
      exp_q  = a / b;
      exp_r  = a % b;
      exp_dz = 1'b0;
    end
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 8'($urandom);
    if (!exp_dz) begin
      nbusy = 0;
      ndone = 0;
      for (int k = 1; k <= 8; k++) begin
        nbusy += int'(bus.busy);
        ndone += int'(bus.done);
        if (poke && k == 3) begin
          bus.start    = 1'b1;
          bus.dividend = 8'd9;
          bus.divisor  = 8'd2;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
      end
      check("busy_cycles", 32'(nbusy), 32'd8);
      check("done_early", 32'(ndone), 32'd0);
    end
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    check("quotient", 32'(bus.quotient), 32'(exp_q));
    check("remainder", 32'(bus.remainder), 32'(exp_r));
    check("div_by_zero", 32'(bus.div_by_zero), 32'(exp_dz));
    @(negedge clk);
    check("done_after", 32'(bus.done), 32'd0);
    check("busy_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int hold_err;
    logic [7:0] ra, rb;
    checks       = 0;
    failures     = 0;
    clk          = 1'b0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 8'd0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quot", 32'(bus.quotient), 32'd0);
    check("rst_rem", 32'(bus.remainder), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_div(8'd200, 8'd7, 1'b0);
    run_div(8'd255, 8'd128, 1'b0);
    run_div(8'd255, 8'd1, 1'b0);
    run_div(8'd5, 8'd9, 1'b0);
    run_div(8'd0, 8'd3, 1'b0);
    run_div(8'd100, 8'd0, 1'b0);
    run_div(8'd100, 8'd10, 1'b0);

    // Start pulse during busy must be ignored; results must then hold.
    run_div(8'd200, 8'd7, 1'b1);
    hold_err = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.quotient !== 8'd28 || bus.remainder !== 8'd4 || bus.done !== 1'b0
          || bus.busy !== 1'b0)
        hold_err++;
      @(negedge clk);
    end
    check("idle_hold", 32'(hold_err), 32'd0);

    // Reset mid-CALC, with start asserted alongside reset.
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst       = 1'b1;
    bus.start = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_quot", 32'(bus.quotient), 32'd0);
    check("mid_rst_rem", 32'(bus.remainder), 32'd0);
    check("mid_rst_dbz", 32'(bus.div_by_zero), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(bus.busy | bus.done), 32'd0);
    run_div(8'd50, 8'd6, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_div(ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
